// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-vector constants, bus widths and FSM encoding for the pipeline controller.
// Stall vector bit order: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved.
package pipe_ctrl_pkg;

    localparam int StallBus    = 6;
    localparam int InstAddrBus = 32;

    localparam logic [StallBus-1:0]    StallNone = 6'b000000;
    localparam logic [StallBus-1:0]    StallIf   = 6'b000011;
    localparam logic [StallBus-1:0]    StallId   = 6'b000111;
    localparam logic [StallBus-1:0]    StallMem  = 6'b011111;
    localparam logic [InstAddrBus-1:0] ZeroWord  = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SHADOW  = 2'd1,
        PEND_BR = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector and branch flush/redirect, zero-cycle latency.
// A memory stall holds everything and defers a concurrent branch until memory frees up.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_mem,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    state_t      state_q, state_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        stall_o     = StallNone;
        flush_o     = 1'b0;
        new_pc_o    = ZeroWord;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (stallreq_mem) begin
                        stall_o = StallMem;
                        // A branch resolved under a memory stall must survive until the stall clears.
                        if (branch_flag_i) begin
                            pend_addr_d = branch_addr_i;
                            state_d     = PEND_BR;
                        end
                    end else if (branch_flag_i) begin
                        flush_o  = 1'b1;
                        new_pc_o = branch_addr_i;
                        state_d  = SHADOW;
                    end else if (stallreq_id) begin
                        stall_o = StallId;
                    end else if (stallreq_if) begin
                        stall_o = StallIf;
                    end
                end
                PEND_BR: begin
                    if (stallreq_mem) begin
                        stall_o = StallMem;
                    end else begin
                        flush_o  = 1'b1;
                        new_pc_o = pend_addr_q;
                        state_d  = SHADOW;
                    end
                end
                SHADOW: begin
                    // ID and EX hold squashed work this cycle, so their requests are ignored.
                    state_d = RUN;
                    if (stallreq_mem) begin
                        stall_o = StallMem;
                    end else if (stallreq_if) begin
                        stall_o = StallIf;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if ((stall_o != StallNone) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end

        flush_cnt_d = flush_cnt_q;
        if (flush_o && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pend_addr_q <= ZeroWord;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: stimulus pushes expected outputs, a monitor pops and compares.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_mem  (stallreq_mem),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .new_pc_o      (new_pc_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          vec;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] scnt;
        logic [15:0] fcnt;
        bit          cnt_chk;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int vec_no = 0;

    // Counter model: values the DUT shows during a cycle are totals of earlier cycles.
    logic [31:0] m_scnt = 32'd0;
    logic [15:0] m_fcnt = 16'd0;
    bit          m_known = 1'b0;

    task automatic apply(input logic r, input logic i_if, input logic i_id, input logic i_mem,
                         input logic br, input logic [31:0] addr,
                         input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                         input bit preload);
        exp_t e;
        @(posedge clk);
        #1;
        if (preload) begin
            force dut.stall_cnt_q = 32'hFFFF_FFFE;
            #1;
            release dut.stall_cnt_q;
            m_scnt = 32'hFFFF_FFFE;
        end
        rst           = r;
        stallreq_if   = i_if;
        stallreq_id   = i_id;
        stallreq_mem  = i_mem;
        branch_flag_i = br;
        branch_addr_i = addr;
        vec_no++;
        e.vec     = vec_no;
        e.stall   = e_stall;
        e.flush   = e_flush;
        e.pc      = e_pc;
        e.scnt    = m_scnt;
        e.fcnt    = m_fcnt;
        e.cnt_chk = m_known;
        exp_q.push_back(e);
        if (r) begin
            m_scnt  = 32'd0;
            m_fcnt  = 16'd0;
            m_known = 1'b1;
        end else begin
            if (e_stall != 6'd0 && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
            if (e_flush && m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (stall_o !== e.stall) begin
                    n_fail++;
                    $display("FAIL stall_o vec %0d: got %b want %b", e.vec, stall_o, e.stall);
                end
                n_cmp++;
                if (flush_o !== e.flush) begin
                    n_fail++;
                    $display("FAIL flush_o vec %0d: got %b want %b", e.vec, flush_o, e.flush);
                end
                n_cmp++;
                if (new_pc_o !== e.pc) begin
                    n_fail++;
                    $display("FAIL new_pc_o vec %0d: got %h want %h", e.vec, new_pc_o, e.pc);
                end
                if (e.cnt_chk) begin
                    n_cmp++;
                    if (stall_cnt_o !== e.scnt) begin
                        n_fail++;
                        $display("FAIL stall_cnt_o vec %0d: got %h want %h", e.vec, stall_cnt_o, e.scnt);
                    end
                    n_cmp++;
                    if (flush_cnt_o !== e.fcnt) begin
                        n_fail++;
                        $display("FAIL flush_cnt_o vec %0d: got %h want %h", e.vec, flush_cnt_o, e.fcnt);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst           = 1'b1;
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_mem  = 1'b0;
        branch_flag_i = 1'b0;
        branch_addr_i = 32'h0;

        //     rst  if   id   mem  br   addr          stall      fl   pc            preload
        // Reset forces outputs to zero whatever the requests.
        apply(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        apply(1'b1,1'b1,1'b1,1'b1,1'b1,32'h1234,     6'b000000,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        // Load-use stall, then fetch stall.
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        6'b000011,1'b0,32'h0,        1'b0);
        // Taken branch, then masked load-use in the shadow cycle, then honoured again.
        apply(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_1040,6'b000000,1'b1,32'h0000_1040,1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0,        1'b0);
        // Shadow ignores a branch flag but honours fetch stall.
        apply(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_3000,6'b000000,1'b1,32'h0000_3000,1'b0);
        apply(1'b0,1'b1,1'b1,1'b0,1'b1,32'h0000_5000,6'b000011,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        // Branch under a 3-cycle memory stall is deferred and flushed on cycle 4.
        apply(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_2000,6'b011111,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_9999,6'b011111,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        6'b011111,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000000,1'b1,32'h0000_2000,1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        // Priority among simultaneous requests.
        apply(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        6'b011111,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0,        1'b0);
        // Reset while a branch is pending discards it.
        apply(1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_7000,6'b011111,1'b0,32'h0,        1'b0);
        apply(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        // Stall counter saturates from a preloaded near-max value.
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0,        1'b1);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);
        apply(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0,        1'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high (`RstEnable == 1'b1).
REQ-003 SHALL have port stallreq_if  in  1  fetch awaiting instruction memory.
REQ-004 SHALL have port stallreq_id  in  1  decode load-use hazard.
REQ-005 SHALL have port stallreq_mem  in  1  data memory busy.
REQ-006 SHALL have port branch_flag_i  in  1  EX resolved a taken branch or jump.
REQ-007 SHALL have port branch_addr_i  in  32  branch/jump target (`InstAddrBus).
REQ-008 SHALL have port stall_o  out  6  per-stage hold: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved, always 0.
REQ-009 SHALL have port flush_o  out  1  squash if_id and id_ex contents this cycle.
REQ-010 SHALL have port new_pc_o  out  32  redirect target, valid only while flush_o == 1.
REQ-011 SHALL have port stall_cnt_o  out  32  total cycles with stall_o != 0, saturating.
REQ-012 SHALL have port flush_cnt_o  out  16  total flushes issued, saturating.

Function
REQ-013 SHALL implement FSM states RUN, SHADOW, PEND_BR.
REQ-014 SHALL compute stall_o, flush_o and new_pc_o combinationally from inputs and state, with zero-cycle latency.
REQ-015 SHALL apply priority: stallreq_mem > branch (live or pending) > stallreq_id > stallreq_if.
REQ-016 SHALL drive stall_o = 6'b011111 while stallreq_mem == 1, with flush_o = 0.
REQ-017 In RUN, SHALL latch branch_addr_i into pend_addr and go to PEND_BR when branch_flag_i && stallreq_mem.
REQ-018 In PEND_BR, SHALL hold pend_addr, ignore branch_flag_i, and keep stall_o = 6'b011111 while stallreq_mem == 1.
REQ-019 In PEND_BR, SHALL drive flush_o = 1, new_pc_o = pend_addr, stall_o = 0 in the first cycle stallreq_mem == 0, then go to SHADOW.
REQ-020 In RUN, SHALL drive flush_o = 1, new_pc_o = branch_addr_i, stall_o = 0 when branch_flag_i && !stallreq_mem, then go to SHADOW.
REQ-021 SHALL keep SHADOW for exactly one cycle and mask stallreq_id there (request belongs to a squashed instruction); SHADOW -> RUN unconditionally.
REQ-022 In SHADOW, SHALL honour stallreq_mem (6'b011111) and stallreq_if (6'b000011).
REQ-023 In SHADOW, SHALL treat branch_flag_i as invalid (EX holds a bubble) and ignore it.
REQ-024 SHALL drive stall_o = 6'b000111 (bubble into id_ex) when stallreq_id is the highest active request.
REQ-025 SHALL drive stall_o = 6'b000011 when stallreq_if is the highest active request.
REQ-026 SHALL drive stall_o = 0 and flush_o = 0 with no request active.
REQ-027 SHALL drive new_pc_o = `ZeroWord whenever flush_o == 0.
REQ-028 SHALL never assert flush_o and a nonzero stall_o in the same cycle.
REQ-029 SHALL increment stall_cnt_o each cycle stall_o != 0, stopping at 32'hFFFFFFFF.
REQ-030 SHALL increment flush_cnt_o each cycle flush_o == 1, stopping at 16'hFFFF.

Reset
REQ-031 On rst == 1 at a clock edge, SHALL set state = RUN, pend_addr = `ZeroWord, stall_cnt_o = 0, flush_cnt_o = 0.
REQ-032 While rst == 1, SHALL force stall_o = 0, flush_o = 0, new_pc_o = `ZeroWord regardless of inputs.
REQ-033 Reset while in PEND_BR SHALL discard the pending branch; no flush after reset release.

Structure
REQ-034 SHALL define stall vector constants (StallNone, StallIf, StallId, StallMem), FSM state encodings and StallBus width in defs.v.
REQ-035 SHALL be a single module with no sub-modules; the counters are inline.

Verification
REQ-036 SHALL check: stallreq_id = 1 alone in RUN -> stall_o = 6'b000111, flush_o = 0, stall_cnt_o + 1 next cycle.
REQ-037 SHALL check: branch_flag_i = 1, addr 32'h0000_1040 in RUN -> flush_o = 1, new_pc_o = 32'h0000_1040 same cycle; next cycle stallreq_id = 1 -> stall_o = 0 (masked).
REQ-038 SHALL check: branch addr 32'h0000_2000 with stallreq_mem = 1 for 3 cycles -> stall_o = 6'b011111 for 3 cycles, then flush_o = 1 and new_pc_o = 32'h0000_2000 on cycle 4, flush_cnt_o + 1.
REQ-039 SHALL check: rst asserted in PEND_BR -> after release, no flush_o, all outputs 0, counters 0.
REQ-040 SHALL check: stallreq_if, stallreq_id and stallreq_mem all = 1 -> stall_o = 6'b011111; with only stallreq_if and stallreq_id -> 6'b000111.
REQ-041 SHALL check: stall_cnt_o preloaded (forced) to 32'hFFFFFFFE with 3 stall cycles -> holds 32'hFFFFFFFF.
